// File: rtl/pwm_counter.sv
// PWM timebase: prescaled up / down / center-aligned counter with double-buffered
// period, prescale and mode, plus single-cycle overflow/underflow pulses.
module pwm_counter #(
    parameter int WIDTH = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             count_reset,
    input  logic [WIDTH-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count_val,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] period_act
);

    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_CTR  = 2'b10;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
    logic [1:0]       mode_sh_q, mode_sh_d;
    logic             dir_down_q, dir_down_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             tick;
    logic             update;
    logic             load_sh;

    assign tick = count_en && (psc_cnt_q == psc_sh_q);

    always_comb begin
        count_d    = count_q;
        psc_cnt_d  = psc_cnt_q;
        dir_down_d = dir_down_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        update     = 1'b0;
        if (count_reset) begin
            count_d    = (mode == MODE_DOWN) ? period : '0;
            psc_cnt_d  = '0;
            dir_down_d = 1'b0;
        end else if (!count_en) begin
            psc_cnt_d = '0;
        end else begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
            if (tick) begin
                case (mode_sh_q)
                    MODE_DOWN: begin
                        dir_down_d = 1'b0;
                        if (count_q == '0) begin
                            count_d = period_act_q;
                            unf_d   = 1'b1;
                            update  = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                    MODE_CTR: begin
                        // A zero period parks the counter at 0 and never turns it down.
                        if (period_act_q == '0) begin
                            count_d    = '0;
                            dir_down_d = 1'b0;
                            unf_d      = 1'b1;
                            update     = 1'b1;
                        end else if (!dir_down_q) begin
                            if (count_q >= period_act_q) begin
                                count_d    = period_act_q - 1'b1;
                                dir_down_d = 1'b1;
                                ovf_d      = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end else if (count_q == '0) begin
                            count_d    = WIDTH'(1);
                            dir_down_d = 1'b0;
                            unf_d      = 1'b1;
                            update     = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                    default: begin
                        dir_down_d = 1'b0;
                        if (count_q >= period_act_q) begin
                            count_d = '0;
                            ovf_d   = 1'b1;
                            update  = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Shadows follow the inputs only at cycle boundaries, so a write never glitches a PWM period.
    assign load_sh      = count_reset || !count_en || update;
    assign period_act_d = load_sh ? period   : period_act_q;
    assign psc_sh_d     = load_sh ? prescale : psc_sh_q;
    assign mode_sh_d    = load_sh ? mode     : mode_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            period_act_q <= '0;
            psc_cnt_q    <= '0;
            psc_sh_q     <= '0;
            mode_sh_q    <= 2'b00;
            dir_down_q   <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            period_act_q <= period_act_d;
            psc_cnt_q    <= psc_cnt_d;
            psc_sh_q     <= psc_sh_d;
            mode_sh_q    <= mode_sh_d;
            dir_down_q   <= dir_down_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign count_val  = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign period_act = period_act_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench for pwm_counter: directed scenarios plus randomized segments
// checked against a phase-based reference model (count derived from ticks since cycle start).
module tb_pwm_counter;
    localparam int WIDTH = 16;
    localparam int PSC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             count_en = 1'b0;
    logic             count_reset = 1'b0;
    logic [WIDTH-1:0] period = '0;
    logic [PSC_W-1:0] prescale = '0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] count_val;
    logic             overflow;
    logic             underflow;
    logic [WIDTH-1:0] period_act;

    int vecs = 0;
    int errs = 0;

    // Model state: shadows, ticks since last cycle start (m_n), count at cycle start (m_s).
    int unsigned m_mode, m_p, m_psc, m_n, m_s, m_pc;
    int unsigned exp_cnt;
    bit          exp_ovf, exp_unf;

    pwm_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .count_reset(count_reset),
        .period(period), .prescale(prescale), .mode(mode),
        .count_val(count_val), .overflow(overflow), .underflow(underflow),
        .period_act(period_act)
    );

    always #5 clk = ~clk;

    task automatic model_init();
        m_mode = 0; m_p = 0; m_psc = 0; m_n = 0; m_s = 0; m_pc = 0;
        exp_cnt = 0; exp_ovf = 0; exp_unf = 0;
    endtask

    task automatic load_shadows();
        m_mode = (mode == 2'b11) ? 32'd0 : 32'(mode);
        m_p    = 32'(period);
        m_psc  = 32'(prescale);
    endtask

    task automatic model_edge();
        int unsigned i, k;
        exp_ovf = 0;
        exp_unf = 0;
        if (count_reset) begin
            load_shadows();
            m_n = 0; m_pc = 0;
            exp_cnt = (m_mode == 1) ? m_p : 0;
            m_s = exp_cnt;
        end else if (!count_en) begin
            load_shadows();
            m_pc = 0;
        end else begin
            m_pc++;
            if (m_pc == m_psc + 1) begin
                m_pc = 0;
                m_n++;
                i = m_n + m_s;
                case (m_mode)
                    1: begin
                        exp_cnt = m_p - ((m_n + m_p - m_s) % (m_p + 1));
                        exp_unf = (exp_cnt == m_p);
                    end
                    2: begin
                        if (m_p == 0) begin
                            exp_cnt = 0; exp_unf = 1;
                        end else begin
                            k = ((i - 1) % (2 * m_p)) + 1;
                            exp_cnt = (k <= m_p) ? k : 2 * m_p - k;
                            exp_ovf = (k == m_p + 1);
                            exp_unf = (k == 1) && (i > 1);
                        end
                    end
                    default: begin
                        exp_cnt = i % (m_p + 1);
                        exp_ovf = (exp_cnt == 0);
                    end
                endcase
                if ((m_mode == 2) ? exp_unf : (exp_ovf || exp_unf)) begin
                    load_shadows();
                    m_n = 0;
                    m_s = exp_cnt;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (count_val !== '0) begin errs++; $display("FAIL reset_count: got %0d want 0", count_val); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL reset_unf: got %b want 0", underflow); end
        vecs++; if (period_act !== '0) begin errs++; $display("FAIL reset_pa: got %0d want 0", period_act); end
        rst_n = 1'b1;
        period = 16'd5;
        step();
        vecs++;
        if (period_act !== 16'd5 || count_val !== '0) begin
            errs++; $display("FAIL disabled_shadow_load: pa=%0d cnt=%0d want pa=5 cnt=0", period_act, count_val);
        end
        $display("test_reset done");
    endtask

    task automatic test_up_basic();
        int novf = 0;
        mode = 2'b00; period = 16'd4; prescale = '0; count_en = 1'b1;
        for (int c = 0; c < 22; c++) begin
            count_reset = (c == 0);
            step();
            if (overflow === 1'b1) novf++;
            vecs++;
            if (count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf || underflow !== exp_unf || period_act !== m_p[WIDTH-1:0]) begin
                errs++; $display("FAIL up_basic c=%0d: cnt=%0d/%0d ovf=%b/%b unf=%b/%b pa=%0d/%0d", c, count_val, exp_cnt, overflow, exp_ovf, underflow, exp_unf, period_act, m_p);
            end
        end
        vecs++;
        if (novf != 4) begin errs++; $display("FAIL up_basic_ovf_count: got %0d want 4", novf); end
        $display("test_up_basic done");
    endtask

    task automatic test_up_prescale_write();
        mode = 2'b00; period = 16'd3; prescale = 8'd2; count_en = 1'b1;
        for (int c = 0; c < 70; c++) begin
            count_reset = (c == 0);
            if (c == 16) period = 16'd7;
            step();
            vecs++;
            if (count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf || underflow !== exp_unf || period_act !== m_p[WIDTH-1:0]) begin
                errs++; $display("FAIL up_psc_write c=%0d: cnt=%0d/%0d ovf=%b/%b unf=%b/%b pa=%0d/%0d", c, count_val, exp_cnt, overflow, exp_ovf, underflow, exp_unf, period_act, m_p);
            end
            if (c == 17) begin
                vecs++;
                if (period_act !== 16'd3) begin errs++; $display("FAIL midcycle_pa: got %0d want 3", period_act); end
            end
        end
        $display("test_up_prescale_write done");
    endtask

    task automatic test_center();
        mode = 2'b10; period = 16'd3; prescale = '0; count_en = 1'b1;
        for (int c = 0; c < 26; c++) begin
            count_reset = (c == 0);
            step();
            vecs++;
            if (count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf || underflow !== exp_unf || period_act !== m_p[WIDTH-1:0]) begin
                errs++; $display("FAIL center c=%0d: cnt=%0d/%0d ovf=%b/%b unf=%b/%b pa=%0d/%0d", c, count_val, exp_cnt, overflow, exp_ovf, underflow, exp_unf, period_act, m_p);
            end
        end
        $display("test_center done");
    endtask

    task automatic test_down();
        mode = 2'b01; period = 16'd5; prescale = '0; count_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            count_reset = (c == 0);
            step();
            vecs++;
            if (count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf || underflow !== exp_unf || period_act !== m_p[WIDTH-1:0]) begin
                errs++; $display("FAIL down c=%0d: cnt=%0d/%0d ovf=%b/%b unf=%b/%b pa=%0d/%0d", c, count_val, exp_cnt, overflow, exp_ovf, underflow, exp_unf, period_act, m_p);
            end
        end
        $display("test_down done");
    endtask

    task automatic test_count_reset();
        mode = 2'b00; period = 16'd9; prescale = 8'd1; count_en = 1'b1;
        for (int c = 0; c < 36; c++) begin
            count_reset = (c == 0) || (c == 8);
            step();
            vecs++;
            if (count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf || underflow !== exp_unf || period_act !== m_p[WIDTH-1:0]) begin
                errs++; $display("FAIL count_reset c=%0d: cnt=%0d/%0d ovf=%b/%b unf=%b/%b pa=%0d/%0d", c, count_val, exp_cnt, overflow, exp_ovf, underflow, exp_unf, period_act, m_p);
            end
            if (c == 8) begin
                vecs++;
                if (count_val !== '0 || overflow !== 1'b0) begin
                    errs++; $display("FAIL count_reset_clear: cnt=%0d ovf=%b want 0/0", count_val, overflow);
                end
            end
        end
        $display("test_count_reset done");
    endtask

    task automatic test_async_reset_p0();
        bit seen = 0;
        mode = 2'b00; period = 16'd2; prescale = '0; count_en = 1'b1;
        for (int c = 0; c < 12 && !seen; c++) begin
            count_reset = (c == 0);
            step();
            seen = (overflow === 1'b1);
        end
        count_reset = 1'b0;
        vecs++;
        if (!seen) begin errs++; $display("FAIL async_wait_ovf: got no overflow within 12 clks want pulse"); end
        period = '0;
        rst_n = 1'b0;
        model_init();
        #1;
        vecs++;
        if (count_val !== '0 || overflow !== 1'b0 || underflow !== 1'b0 || period_act !== '0) begin
            errs++; $display("FAIL async_reset: cnt=%0d ovf=%b unf=%b pa=%0d want all 0", count_val, overflow, underflow, period_act);
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            vecs++;
            if (count_val !== '0 || overflow !== 1'b1 || underflow !== 1'b0 || count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf) begin
                errs++; $display("FAIL p0_up c=%0d: cnt=%0d ovf=%b unf=%b want 0/1/0", c, count_val, overflow, underflow);
            end
        end
        $display("test_async_reset_p0 done");
    endtask

    task automatic test_random();
        int unsigned kind, len, wr_at, sel;
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(30, 80);
            wr_at = $urandom_range(5, len - 10);
            prescale = PSC_W'($urandom_range(0, 3));
            if (kind == 2) begin
                sel = $urandom_range(0, 2);
                mode = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
                period = WIDTH'($urandom_range(1, 10));
            end else begin
                mode = 2'($urandom_range(0, 3));
                period = WIDTH'($urandom_range(0, 10));
            end
            $display("random seg %0d kind=%0d mode=%0d P=%0d psc=%0d len=%0d", s, kind, mode, period, prescale, len);
            for (int c = 0; c < int'(len); c++) begin
                count_reset = (c == 0);
                count_en = (kind == 1 && c != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (kind == 2 && c == int'(wr_at)) begin
                    sel = $urandom_range(0, 2);
                    mode = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
                    period = WIDTH'($urandom_range(1, 10));
                    prescale = PSC_W'($urandom_range(0, 3));
                end
                step();
                vecs++;
                if (count_val !== exp_cnt[WIDTH-1:0] || overflow !== exp_ovf || underflow !== exp_unf || period_act !== m_p[WIDTH-1:0]) begin
                    errs++; $display("FAIL random s=%0d c=%0d: cnt=%0d/%0d ovf=%b/%b unf=%b/%b pa=%0d/%0d", s, c, count_val, exp_cnt, overflow, exp_ovf, underflow, exp_unf, period_act, m_p);
                end
            end
        end
        count_reset = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_up_basic();
        test_up_prescale_write();
        test_center();
        test_down();
        test_count_reset();
        test_async_reset_p0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
